// File: rtl/defines.sv
// Shared types and constants for the Ethernet frame datapath.
package defines;

  typedef struct packed {
    logic [5:0][7:0] dst;
    logic [5:0][7:0] src;
  } address;

  typedef enum logic [2:0] {
    IDLE,
    DST,
    SRC,
    LEN,
    PAYLOAD,
    DROP
  } rx_state_t;

  localparam int unsigned MAC_BYTES = 6;
  localparam int unsigned LEN_BYTES = 2;
  localparam int unsigned HDR_BYTES = 14;

endpackage

// File: rtl/rx_byte_fifo.sv
// Byte-wide synchronous FIFO with show-ahead head; extra pointer bit tells full from empty.
module rx_byte_fifo #(
  parameter int unsigned DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/eth_frame_receiver.sv
// Parses the 14-byte Ethernet header from a byte stream and buffers payload for a byte consumer.
module eth_frame_receiver
  import defines::*;
#(
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned MAX_PAYLOAD = 1500
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_axis_tdata,
  input  logic            rx_axis_tvalid,
  input  logic            rx_axis_tlast,
  output logic            rx_axis_tready,
  output defines::address header_addr,
  output logic [1:0][7:0] number_of_bytes,
  output logic            rx_header_valid,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            brx_empty,
  output logic            brx_full,
  output logic            rx_frame_err
);

  rx_state_t       state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  address          addr_q, addr_d;
  logic [1:0][7:0] len_q, len_d;
  logic [15:0]     pay_cnt_q, pay_cnt_d;
  logic            hdr_valid_q, hdr_valid_d;
  logic            err_q, err_d;
  logic            accept, fifo_push;
  logic [15:0]     len_value;

  // Full is a registered-pointer comparison, so tready never depends on rx_ready.
  assign rx_axis_tready = (state_q != PAYLOAD) || !brx_full;
  assign accept         = rx_axis_tvalid && rx_axis_tready;
  assign len_value      = {len_q[1], rx_axis_tdata};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    pay_cnt_d   = pay_cnt_q;
    hdr_valid_d = 1'b0;
    err_d       = 1'b0;
    fifo_push   = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          addr_d.dst[5] = rx_axis_tdata;
          if (rx_axis_tlast) begin
            err_d = 1'b1;
          end else begin
            state_d = DST;
            cnt_d   = 3'd1;
          end
        end
        DST: begin
          addr_d.dst[3'd5 - cnt_q] = rx_axis_tdata;
          if (rx_axis_tlast) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == 3'(MAC_BYTES - 1)) begin
            state_d = SRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        SRC: begin
          addr_d.src[3'd5 - cnt_q] = rx_axis_tdata;
          if (rx_axis_tlast) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == 3'(MAC_BYTES - 1)) begin
            state_d = LEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        LEN: begin
          if (cnt_q != 3'(LEN_BYTES - 1)) begin
            len_d[1] = rx_axis_tdata;
            if (rx_axis_tlast) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            len_d[0] = rx_axis_tdata;
            if (rx_axis_tlast) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else if (len_value == '0 || len_value > 16'(MAX_PAYLOAD)) begin
              err_d   = 1'b1;
              state_d = DROP;
            end else begin
              hdr_valid_d = 1'b1;
              pay_cnt_d   = len_value;
              state_d     = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          fifo_push = 1'b1;
          pay_cnt_d = pay_cnt_q - 16'd1;
          // Bytes beyond the length field without tlast are padding.
          if (pay_cnt_q == 16'd1) begin
            state_d = rx_axis_tlast ? IDLE : DROP;
          end else if (rx_axis_tlast) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        DROP: begin
          if (rx_axis_tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      pay_cnt_q   <= '0;
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      pay_cnt_q   <= pay_cnt_d;
      hdr_valid_q <= hdr_valid_d;
      err_q       <= err_d;
    end
  end

  rx_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(rx_axis_tdata),
    .pop      (rx_ready),
    .rd_data  (rx_data),
    .empty    (brx_empty),
    .full     (brx_full)
  );

  assign header_addr     = addr_q;
  assign number_of_bytes = len_q;
  assign rx_header_valid = hdr_valid_q;
  assign rx_frame_err    = err_q;
  assign rx_valid        = !brx_empty;

endmodule

// File: tb/tb_eth_frame_receiver.sv
// Randomized scoreboard bench for eth_frame_receiver against a frame-level reference model.
module tb_eth_frame_receiver;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      rx_axis_tdata = '0;
  logic            rx_axis_tvalid = 1'b0;
  logic            rx_axis_tlast = 1'b0;
  logic            rx_axis_tready;
  defines::address header_addr;
  logic [1:0][7:0] number_of_bytes;
  logic            rx_header_valid;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ready = 1'b1;
  logic            brx_empty;
  logic            brx_full;
  logic            rx_frame_err;

  eth_frame_receiver #(
    .FIFO_DEPTH (64),
    .MAX_PAYLOAD(1500)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_axis_tdata  (rx_axis_tdata),
    .rx_axis_tvalid (rx_axis_tvalid),
    .rx_axis_tlast  (rx_axis_tlast),
    .rx_axis_tready (rx_axis_tready),
    .header_addr    (header_addr),
    .number_of_bytes(number_of_bytes),
    .rx_header_valid(rx_header_valid),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .brx_empty      (brx_empty),
    .brx_full       (brx_full),
    .rx_frame_err   (rx_frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int stalls = 0;
  int ready_mode = 0;  // 0: always ready, 1: never ready, 2: random

  logic [111:0] exp_hdr_q[$];
  logic [7:0]   exp_byte_q[$];
  int           pending_err = 0;
  logic [7:0]   frm[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: the whole frame's expected outcome from its byte list.
  task automatic model_frame(input logic [7:0] f[$]);
    int n, l, keep;
    logic [111:0] h;
    n = f.size();
    if (n <= 14) begin
      pending_err++;
      return;
    end
    l = {f[12], f[13]};
    if (l == 0 || l > 1500) begin
      pending_err++;
      return;
    end
    h = '0;
    for (int k = 0; k < 14; k++) h = {h[103:0], f[k]};
    exp_hdr_q.push_back(h);
    keep = (n - 14 < l) ? n - 14 : l;
    for (int k = 0; k < keep; k++) exp_byte_q.push_back(f[14 + k]);
    if (n - 14 < l) pending_err++;
  endtask

  task automatic build(input int len_field, input int n_pay, input int mac, input int fill);
    frm.delete();
    for (int k = 0; k < 12; k++) frm.push_back(mac < 0 ? 8'($urandom) : 8'(mac));
    frm.push_back(8'(len_field >> 8));
    frm.push_back(8'(len_field));
    for (int k = 0; k < n_pay; k++) frm.push_back(fill < 0 ? 8'($urandom) : 8'(fill));
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input bit gaps);
    int wait_c = 0;
    if (gaps && $urandom_range(3) == 0) begin
      rx_axis_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    rx_axis_tvalid = 1'b1;
    rx_axis_tdata  = d;
    rx_axis_tlast  = last;
    while (!rx_axis_tready) begin
      stalls++;
      @(posedge clk); #1;
      wait_c++;
      if (wait_c > 2000) begin
        checks++;
        errors++;
        $display("FAIL tready_timeout: got tready=0 for %0d cycles required 1", wait_c);
        break;
      end
    end
    @(posedge clk); #1;
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    beats++;
  endtask

  task automatic send_frame(input int n_send, input bit gaps);
    for (int i = 0; i < n_send; i++) send_beat(frm[i], (i == frm.size() - 1), gaps);
  endtask

  always begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       rx_ready = 1'b1;
      1:       rx_ready = 1'b0;
      default: rx_ready = 1'($urandom_range(1));
    endcase
  end

  // Monitor: compares every DUT-presented event against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx_header_valid) begin
          if (exp_hdr_q.size() == 0) chk("unexpected_header", 1, 0);
          else chk("header", {header_addr, number_of_bytes}, exp_hdr_q.pop_front());
        end
        if (rx_frame_err) begin
          if (pending_err == 0) chk("unexpected_frame_err", 1, 0);
          else begin
            pending_err--;
            chk("frame_err", 1, 1);
          end
        end
        if (rx_valid && rx_ready) begin
          if (exp_byte_q.size() == 0) chk("unexpected_byte", {8'h0, rx_data}, 0);
          else chk("payload_byte", rx_data, exp_byte_q.pop_front());
        end
      end
    end
  end

  initial begin
    int typ, l, w;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_empty", brx_empty, 1);
    chk("reset_full", brx_full, 0);
    chk("reset_valid", rx_valid, 0);
    chk("reset_header", {header_addr, number_of_bytes}, 0);
    @(posedge clk); #1;

    // Basic frame: all-3F MACs, 32 bytes of CC
    build(16'h0020, 32, 8'h3F, 8'hCC);
    model_frame(frm);
    send_frame(frm.size(), 0);

    // Length 4 with 42 pad bytes; no stalls expected
    build(16'h0004, 46, -1, -1);
    frm[14] = 8'hAA; frm[15] = 8'hBB; frm[16] = 8'hCC; frm[17] = 8'hDD;
    model_frame(frm);
    stalls = 0;
    send_frame(frm.size(), 0);
    chk("pad_no_stall", stalls, 0);

    // Backpressure: 80-byte payload with consumer stalled
    w = 0;
    while ((exp_byte_q.size() != 0) && w < 500) begin @(posedge clk); #1; w++; end
    ready_mode = 1;
    build(16'h0050, 80, -1, -1);
    model_frame(frm);
    beats = 0;
    fork
      send_frame(frm.size(), 0);
      begin
        w = 0;
        do begin @(negedge clk); w++; end while (!brx_full && w < 500);
        chk("full_reached", brx_full, 1);
        chk("beats_at_full", beats, 14 + 64);
        chk("tready_low_full", rx_axis_tready, 0);
        repeat (20) @(negedge clk);
        chk("still_full", brx_full, 1);
        chk("no_beats_while_full", beats, 14 + 64);
        ready_mode = 0;
      end
    join

    // tlast inside SRC, then a good frame
    build(16'h0010, 0, -1, -1);
    frm = frm[0:8];
    model_frame(frm);
    send_frame(frm.size(), 0);
    build(16'h0008, 8, -1, -1);
    model_frame(frm);
    send_frame(frm.size(), 0);

    // Oversize length, boundary lengths, short payload
    build(16'h0800, 20, -1, -1); model_frame(frm); send_frame(frm.size(), 0);
    build(1501, 5, -1, -1);      model_frame(frm); send_frame(frm.size(), 0);
    build(0, 3, -1, -1);         model_frame(frm); send_frame(frm.size(), 0);
    build(16'h0010, 5, -1, -1);  model_frame(frm); send_frame(frm.size(), 0);
    ready_mode = 2;
    build(1500, 1500, -1, -1);   model_frame(frm); send_frame(frm.size(), 1);

    // Random mix of frame shapes
    for (int i = 0; i < 24; i++) begin
      typ = $urandom_range(4);
      l = $urandom_range(40, 1);
      case (typ)
        0: build(l, l, -1, -1);
        1: build(l, l + $urandom_range(10, 1), -1, -1);
        2: build(l + 1, $urandom_range(l, 0), -1, -1);
        3: build($urandom_range(1) ? 0 : $urandom_range(16'hFFFF, 1501), $urandom_range(8), -1, -1);
        default: begin
          build(l, 0, -1, -1);
          frm = frm[0:$urandom_range(13)];
        end
      endcase
      model_frame(frm);
      send_frame(frm.size(), 1);
    end

    // Reset in mid-payload, then an immediate complete frame
    ready_mode = 2;
    build(16'h0028, 40, -1, -1);
    model_frame(frm);
    send_frame(24, 0);
    ready_mode = 1;
    rx_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_byte_q.delete();
    exp_hdr_q.delete();
    pending_err = 0;
    ready_mode = 0;
    build(16'h000C, 12, -1, -1);
    model_frame(frm);
    fork
      send_frame(frm.size(), 0);
      begin
        @(negedge clk);
        chk("rst_mid_empty", brx_empty, 1);
        chk("rst_mid_valid", rx_valid, 0);
        chk("rst_mid_data", rx_data, 0);
        chk("rst_mid_full", brx_full, 0);
        chk("rst_mid_pulses", {rx_header_valid, rx_frame_err}, 0);
        chk("rst_mid_header", {header_addr, number_of_bytes}, 0);
      end
    join

    ready_mode = 0;
    w = 0;
    while ((exp_byte_q.size() != 0 || exp_hdr_q.size() != 0 || pending_err != 0) && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    repeat (4) @(negedge clk);
    chk("drain_bytes_left", exp_byte_q.size(), 0);
    chk("drain_headers_left", exp_hdr_q.size(), 0);
    chk("drain_errs_left", pending_err, 0);
    chk("final_empty", brx_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_frame_receiver.md
Name: eth_frame_receiver

Overview:
- Receive-side counterpart of the frame transmitter.
- Accepts a byte-wide AXI-Stream frame from the tri-mode Ethernet MAC RX interface and parses the 14-byte header: destination MAC, source MAC and 2-byte length.
- Presents the parsed header with a one-cycle valid pulse, then buffers payload bytes in an internal FIFO for a byte-wide consumer.
- Discards pad bytes, detects malformed frames and flags them.

Parameters:
- FIFO_DEPTH, 64, payload FIFO depth in bytes; power of two, at least 4.
- MAX_PAYLOAD, 1500, largest legal length field value.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous to clk, active-high
- rx_axis_tdata  in  8  MAC RX stream byte
- rx_axis_tvalid  in  1  stream byte valid
- rx_axis_tlast  in  1  last byte of frame
- rx_axis_tready  out  1  receiver accepts the byte this cycle
- header_addr  out  address  parsed dst/src MACs (defines::address)
- number_of_bytes  out  [1:0][7:0]  parsed length field
- rx_header_valid  out  1  one-cycle pulse: header_addr/number_of_bytes valid
- rx_data  out  8  FIFO head byte (show-ahead)
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer pops head when rx_valid && rx_ready
- brx_empty  out  1  FIFO empty
- brx_full  out  1  FIFO full
- rx_frame_err  out  1  one-cycle pulse on malformed frame

Behaviour:
- Beat accepted when rx_axis_tvalid && rx_axis_tready.
- rx_axis_tready = 1 in every state except PAYLOAD; in PAYLOAD it equals !brx_full (registered full, no combinational path from rx_ready).
- Reset values: FSM in IDLE; header_addr = 0; number_of_bytes = 0; rx_header_valid = 0; rx_frame_err = 0; FIFO pointers cleared; brx_empty = 1; brx_full = 0; rx_valid = 0; rx_data = 0.
- Reset mid-frame: FIFO is flushed and the FSM returns to IDLE. Remaining beats of that frame are consumed as a new frame and will normally be flagged as errors.
- FSM states: IDLE, DST, SRC, LEN, PAYLOAD, DROP. A byte counter cnt tracks position within the current field.
- IDLE: the first accepted beat is dst byte 0 and is stored in header_addr.dst[5]; go to DST with cnt = 1.
- DST: wire byte k goes to dst[5-k]. After the 6th byte, go to SRC with cnt = 0.
- SRC: same ordering into src[5..0]. After the 6th byte, go to LEN.
- LEN: the first byte goes to number_of_bytes[1], the second to number_of_bytes[0].
- After the second LEN byte is accepted, evaluate the length L:
  - L == 0, or L > MAX_PAYLOAD: pulse rx_frame_err, go to DROP. rx_header_valid is not pulsed.
  - Otherwise: pulse rx_header_valid in the following cycle, load the payload counter with L, go to PAYLOAD.
- tlast on any header beat (IDLE/DST/SRC/LEN): pulse rx_frame_err next cycle; return to IDLE; no header pulse.
- PAYLOAD: each accepted beat is pushed to the FIFO and the counter decrements.
  - Counter reaches 0 with tlast: frame complete; go to IDLE.
  - Counter reaches 0 without tlast: the remainder is Ethernet padding; go to DROP with no error.
  - tlast while counter > 1: short frame. The byte is pushed, rx_frame_err pulses, go to IDLE. Bytes already pushed stay in the FIFO; the consumer discards them on error.
- DROP: accept and discard beats until tlast, then go to IDLE.
- Latency:
  - Header pulse is 1 cycle after the last LEN beat.
  - A payload byte accepted in cycle N appears at rx_data with rx_valid in cycle N+1 if the FIFO was empty.
- FIFO:
  - Simultaneous push and pop is allowed at any occupancy except push when full, which cannot occur because tready gates it.
  - Pop when empty is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Back-to-back frames: a new frame's first beat may arrive in the cycle after tlast; IDLE must accept it with no bubble.

Decomposition:
- Add to package defines:
  - rx_state_t enum (IDLE, DST, SRC, LEN, PAYLOAD, DROP)
  - MAC_BYTES = 6
  - LEN_BYTES = 2
  - HDR_BYTES = 14
- Reuse the existing address struct from defines.
- Sub-module rx_byte_fifo: parameterised synchronous FIFO with show-ahead output, push/pop/full/empty. The FSM and header registers stay in eth_frame_receiver.

Test Plan:
- Frame: dst = src = 3F×6, length 0x0020, 32 bytes of 0xCC, tlast on byte 32, rx_ready = 1 → header_addr all 3F, number_of_bytes = {00,20}, exactly one rx_header_valid pulse, 32 pops of 0xCC, rx_frame_err never asserts.
- Length 0x0004, 46 payload beats (4 data bytes AA,BB,CC,DD then 42 pad bytes) → exactly 4 bytes reach the FIFO, no error, tready high throughout, FSM back in IDLE after tlast.
- rx_ready = 0, length 0x0050 (80 bytes), FIFO_DEPTH = 64 → brx_full after 64 bytes, tready low, stream stalls. Raise rx_ready → all 80 bytes received in order with no loss or duplication.
- tlast on byte 9 (inside SRC) → rx_frame_err pulse, no header pulse, next well-formed frame parsed correctly.
- Length 0x0800 (exceeds MAX_PAYLOAD) → rx_frame_err, FIFO stays empty, all beats accepted until tlast. Separately: length 0x0010 with tlast on payload byte 5 → 5 bytes in FIFO plus rx_frame_err.
- Assert rst in the middle of a payload → the cycle after reset FIFO empty, rx_valid = 0, all outputs at reset values; a following complete frame with no gap is parsed correctly.
